// File: rtl/voice_scheduler_pkg.sv
// Shared widths, the per-voice parameter bundle and the attack/decay clamp
// used by the voice scheduler and its voice slots.
package voice_scheduler_pkg;

  localparam int AMP_W      = 3;
  localparam int TIME_W     = 6;
  localparam int MAX_VOICES = 8;

  // Everything a dynamics unit needs to start a note.
  typedef struct packed {
    logic [AMP_W-1:0]  amp;
    logic [TIME_W-1:0] duration;
    logic [TIME_W-1:0] attack;
    logic [TIME_W-1:0] decay;
  } voice_params_t;

  // Smaller of two beat counts.
  function automatic logic [TIME_W-1:0] min_time(input logic [TIME_W-1:0] a,
                                                 input logic [TIME_W-1:0] b);
    if (a < b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Attack is capped at the duration and decay at whatever time the attack
  // leaves, so attack + decay never exceeds duration and nothing wraps.
  function automatic voice_params_t clamp_note(input logic [AMP_W-1:0]  amp,
                                               input logic [TIME_W-1:0] duration,
                                               input logic [TIME_W-1:0] attack,
                                               input logic [TIME_W-1:0] decay);
    voice_params_t p;
    p.amp      = amp;
    p.duration = duration;
    p.attack   = min_time(attack, duration);
    p.decay    = min_time(decay, duration - p.attack);
    return p;
  endfunction

endpackage

// File: rtl/voice_scheduler_if.sv
// Note handshake between the song/note reader (master) and the scheduler (slave).
interface voice_scheduler_if;
  import voice_scheduler_pkg::*;

  logic              note_valid;
  logic              note_ready;
  logic [AMP_W-1:0]  note_amp;
  logic [TIME_W-1:0] note_duration;
  logic [TIME_W-1:0] note_attack;
  logic [TIME_W-1:0] note_decay;

  modport master (
    output note_valid, note_amp, note_duration, note_attack, note_decay,
    input  note_ready
  );

  modport slave (
    input  note_valid, note_amp, note_duration, note_attack, note_decay,
    output note_ready
  );

endinterface

// File: rtl/voice_scheduler_slot.sv
// One voice slot: holds the parameters of the note it is playing and counts
// the note's remaining beats; busy drops on the beat after the count hits 0.
module voice_slot
  import voice_scheduler_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          beat,
  input  voice_params_t params_in,
  output voice_params_t params_out,
  output logic          busy
);

  voice_params_t     params_d, params_q;
  logic [TIME_W-1:0] remaining_d, remaining_q;
  logic              busy_d, busy_q;

  // Next state: a load takes priority over a coincident beat.
  always_comb begin
    params_d    = params_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    if (load) begin
      params_d    = params_in;
      remaining_d = params_in.duration;
      busy_d      = 1'b1;
    end else if (beat && busy_q) begin
      if (remaining_q == {TIME_W{1'b0}}) begin
        busy_d = 1'b0;
      end else begin
        remaining_d = remaining_q - TIME_W'(1);
      end
    end else begin
      busy_d = busy_q;
    end
  end

  // Slot state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      params_q    <= '0;
      remaining_q <= {TIME_W{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      params_q    <= params_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
    end
  end

  assign params_out = params_q;
  assign busy       = busy_q;

endmodule

// File: rtl/voice_scheduler.sv
// Allocates incoming notes to the lowest-numbered free voice slot, clamps the
// envelope times, pulses the chosen voice's new_note and stalls the reader
// while every voice is busy or playback is paused.
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         beat,
  input  logic                         play_enable,
  voice_scheduler_if.slave             note_bus,
  output logic [NUM_VOICES-1:0]        voice_new_note,
  output logic [AMP_W*NUM_VOICES-1:0]  voice_amp,
  output logic [TIME_W*NUM_VOICES-1:0] voice_duration,
  output logic [TIME_W*NUM_VOICES-1:0] voice_attack,
  output logic [TIME_W*NUM_VOICES-1:0] voice_decay,
  output logic [NUM_VOICES-1:0]        voice_busy
);

  logic [NUM_VOICES-1:0] busy_s;
  logic [NUM_VOICES-1:0] free_s;
  logic [NUM_VOICES-1:0] sel_s;
  logic [NUM_VOICES-1:0] load_s;
  logic                  ready_s;
  logic                  accept_s;
  voice_params_t         clamped_s;
  logic [NUM_VOICES-1:0] new_note_d, new_note_q;

  // Ready depends only on registered busy, so a slot freed this cycle is
  // offered from the next one. Held low while reset is asserted.
  assign ready_s             = ~reset & play_enable & ~(&busy_s);
  assign note_bus.note_ready = ready_s;
  assign accept_s            = note_bus.note_valid & ready_s;

  // Lowest free slot: isolate the least significant set bit of the free mask.
  assign free_s = ~busy_s;
  assign sel_s  = free_s & (~free_s + NUM_VOICES'(1));
  assign load_s = sel_s & {NUM_VOICES{accept_s}};

  assign clamped_s = clamp_note(note_bus.note_amp, note_bus.note_duration,
                                note_bus.note_attack, note_bus.note_decay);

  // The load pulse is delayed one cycle so it lines up with the loaded params.
  always_comb begin
    new_note_d = load_s;
  end

  // new_note pulse register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      new_note_q <= {NUM_VOICES{1'b0}};
    end else begin
      new_note_q <= new_note_d;
    end
  end

  assign voice_new_note = new_note_q;
  assign voice_busy     = busy_s;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_params_t slot_params_s;

    voice_slot u_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (load_s[i]),
      .beat       (beat),
      .params_in  (clamped_s),
      .params_out (slot_params_s),
      .busy       (busy_s[i])
    );

    assign voice_amp[AMP_W*i +: AMP_W]       = slot_params_s.amp;
    assign voice_duration[TIME_W*i +: TIME_W] = slot_params_s.duration;
    assign voice_attack[TIME_W*i +: TIME_W]   = slot_params_s.attack;
    assign voice_decay[TIME_W*i +: TIME_W]    = slot_params_s.decay;
  end

endmodule
